vga_fetch_ctrl: RTL and testbench

//  Frame-buffer fetch scheduler for the 640x480 bitplane video output.

---
 rtl/vga_fetch_ctrl.sv | 206 ++++++++++++++++++++
 tb/tb_vga_fetch_ctrl.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// vga_fetch_ctrl
//   Frame-buffer fetch scheduler for the bitplane video output. Streams
//   FRAME_WORDS 32-bit words per frame from RAM in bursts of up to BURST
//   beats and holds them in a show-ahead FIFO that the video block pops one
//   word per rd pulse. A falling edge on vga_vsync restarts the frame at
//   base_addr.
//
// Ports
//   clk          system / bus clock, all logic on its rising edge
//   reset_n      asynchronous active-low reset
//   enable       1 = new bursts may be issued (a burst in flight always ends)
//   base_addr    frame-buffer word address, sampled at frame start
//   vga_vsync    active-low vsync from the pixel domain (asynchronous)
//   rd           one-clock pop pulse from the video block
//   red_byte     FIFO head word[7:0]
//   green_byte   FIFO head word[15:8]
//   blue_byte    FIFO head word[23:16]
//   bright_byte  FIFO head word[31:24]
//   bus_req      read request, held until the last ack of the burst
//   bus_addr     word address of the current beat
//   bus_ack      one beat of data valid on bus_rdata
//   bus_rdata    read data
//   underrun     sticky: rd seen while the FIFO was empty; cleared at frame start
// ---------------------------------------------------------------------------
module vga_fetch_ctrl #(
    parameter int ADDR_W      = 30,
    parameter int FIFO_DEPTH  = 16,
    parameter int BURST       = 4,
    parameter int FRAME_WORDS = 38400
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              enable,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              vga_vsync,
    input  logic              rd,
    output logic [7:0]        red_byte,
    output logic [7:0]        green_byte,
    output logic [7:0]        blue_byte,
    output logic [7:0]        bright_byte,
    output logic              bus_req,
    output logic [ADDR_W-1:0] bus_addr,
    input  logic              bus_ack,
    input  logic [31:0]       bus_rdata,
    output logic              underrun
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int WL_W  = $clog2(((FRAME_WORDS > BURST) ? FRAME_WORDS : BURST) + 1);
    localparam int BT_W  = $clog2(BURST + 1);

    localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] BURST_CNT = CNT_W'(BURST);
    localparam logic [WL_W-1:0]  BURST_WL  = WL_W'(BURST);
    localparam logic [WL_W-1:0]  FRAME_C   = WL_W'(FRAME_WORDS);
    localparam logic [BT_W-1:0]  BURST_BT  = BT_W'(BURST);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_BURST,
        S_GAP,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [2:0]         vs_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [WL_W-1:0]    words_left_q;
    logic [BT_W-1:0]    beats_q;
    logic               underrun_q;
    logic [31:0]        mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]   count_q;
    logic [31:0]        head_q;

    logic               frame_start;
    logic [CNT_W-1:0]   free_w;
    logic               issue;
    logic               ack_ok;
    logic               last_beat;
    logic               fifo_empty;
    logic               do_push, do_pop;
    logic [BT_W-1:0]    n_beats;
    logic [PTR_W-1:0]   rd_ptr_inc;

    // vs_q[1:0] is the two-flop synchronizer, vs_q[2] the edge-detect history.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) vs_q <= '0;
        else          vs_q <= {vs_q[1:0], vga_vsync};
    end

    assign frame_start = vs_q[2] & ~vs_q[1];

    // Free space counts slots already promised to the beats still in flight,
    // so a burst is only launched when every beat has somewhere to land.
    assign free_w     = DEPTH_C - count_q - CNT_W'(beats_q);
    assign fifo_empty = (count_q == '0);
    assign issue      = (state_q == S_FILL) && !frame_start && enable &&
                        (words_left_q != '0) && (free_w >= BURST_CNT);
    // An ack coinciding with frame start belongs to the old frame: drop it.
    assign ack_ok     = bus_ack && (state_q == S_BURST) && !frame_start;
    assign last_beat  = ack_ok && (beats_q == BT_W'(1));
    assign do_push    = ack_ok;
    assign do_pop     = rd && !fifo_empty && !frame_start;
    assign n_beats    = (words_left_q < BURST_WL) ? BT_W'(words_left_q) : BURST_BT;
    assign rd_ptr_inc = rd_ptr_q + PTR_W'(1);

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        if (frame_start) begin
            state_d = S_FILL;
        end else begin
            case (state_q)
                S_IDLE:  state_d = S_IDLE;
                S_FILL: begin
                    if (words_left_q == '0) state_d = S_DONE;
                    else if (issue)         state_d = S_BURST;
                end
                S_BURST: if (last_beat) state_d = S_GAP;
                S_GAP:   state_d = S_FILL;
                S_DONE:  state_d = S_DONE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        bus_req = (state_q == S_BURST);
    end

    // ---------------- address / frame bookkeeping ----------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr_q       <= '0;
            words_left_q <= '0;
            beats_q      <= '0;
            underrun_q   <= 1'b0;
        end else if (frame_start) begin
            addr_q       <= base_addr;
            words_left_q <= FRAME_C;
            beats_q      <= '0;
            underrun_q   <= 1'b0;
        end else begin
            if (issue) beats_q <= n_beats;
            if (ack_ok) begin
                addr_q       <= addr_q + ADDR_W'(1);
                words_left_q <= words_left_q - WL_W'(1);
                beats_q      <= beats_q - BT_W'(1);
            end
            if (rd && fifo_empty) underrun_q <= 1'b1;
        end
    end

    // ---------------- FIFO storage (no reset on the array) ----------------
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= bus_rdata;
    end

    // head_q is the word shown on the outputs. It is loaded ahead of time so
    // the next entry is already visible the clock after a pop, and it simply
    // keeps the last popped word once the FIFO runs dry.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= '0;
        end else if (frame_start) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_inc;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
            if (do_push && (fifo_empty || (do_pop && count_q == CNT_W'(1))))
                head_q <= bus_rdata;
            else if (do_pop && count_q > CNT_W'(1))
                head_q <= mem_q[rd_ptr_inc];
        end
    end

    assign red_byte    = head_q[7:0];
    assign green_byte  = head_q[15:8];
    assign blue_byte   = head_q[23:16];
    assign bright_byte = head_q[31:24];
    assign bus_addr    = addr_q;
    assign underrun    = underrun_q;

endmodule

// File: tb/tb_vga_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// tb_vga_fetch_ctrl
//   Bench for vga_fetch_ctrl. A queue-based reference model tracks the words
//   the frame should deliver, the visible head word, underrun and burst
//   shape; directed sequences and a table cover fixed timing corner cases,
//   and a random phase exercises enable / ack / rd / vsync mixes.
// ---------------------------------------------------------------------------
module tb_vga_fetch_ctrl;

    localparam int AW    = 30;
    localparam int DEPTH = 16;
    localparam int BL    = 4;
    localparam int FW    = 22;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          enable;
    logic [AW-1:0] base_addr;
    logic          vga_vsync;
    logic          rd;
    logic          bus_ack;
    logic [31:0]   bus_rdata;
    logic [7:0]    red_byte, green_byte, blue_byte, bright_byte;
    logic          bus_req;
    logic [AW-1:0] bus_addr;
    logic          underrun;

    vga_fetch_ctrl #(
        .ADDR_W(AW), .FIFO_DEPTH(DEPTH), .BURST(BL), .FRAME_WORDS(FW)
    ) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .base_addr(base_addr),
        .vga_vsync(vga_vsync), .rd(rd),
        .red_byte(red_byte), .green_byte(green_byte), .blue_byte(blue_byte),
        .bright_byte(bright_byte),
        .bus_req(bus_req), .bus_addr(bus_addr), .bus_ack(bus_ack),
        .bus_rdata(bus_rdata), .underrun(underrun)
    );

    always #5 clk = ~clk;

    // Memory content: a word that identifies its own address.
    function automatic logic [31:0] fword(input logic [AW-1:0] a);
        fword = {a[7:0] ^ 8'hA5, a[23:16], a[15:8], a[7:0]};
    endfunction

    assign bus_rdata = fword(bus_addr);

    int tests  = 0;
    int failed = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // ---------------- reference model state ----------------
    logic [31:0]   mq[$];
    logic [31:0]   last_m;
    logic          und_m;
    logic [AW-1:0] addr_m;
    int            pushed_m;
    logic [2:0]    vh;          // vsync as seen at the last three edges
    int            in_burst, burst_acks, burst_len_exp, low_steps;
    logic          after_end;
    logic [AW-1:0] b_addr[$];
    int            b_len[$];

    task automatic model_reset();
        mq.delete();
        last_m   = '0;
        und_m    = 1'b0;
        addr_m   = '0;
        pushed_m = FW;          // nothing may be fetched before a frame start
        vh       = '0;
        in_burst = 0; burst_acks = 0; burst_len_exp = 0; low_steps = 0;
        after_end = 1'b0;
    endtask

    function automatic logic [31:0] dut_word();
        dut_word = {bright_byte, blue_byte, green_byte, red_byte};
    endfunction

    // One clock: inputs already set at this negedge; advance to the next
    // negedge, update the model and compare.
    task automatic step();
        logic          req_b, en_b, ack_b, rd_b, fs;
        logic [AW-1:0] addr_b, base_b;
        int            size_pre, remain;
        req_b = bus_req; addr_b = bus_addr; en_b = enable;
        ack_b = bus_ack; rd_b = rd; base_b = base_addr; size_pre = mq.size();
        // A frame begins three clocks after vsync is first seen low.
        fs = vh[2] & ~vh[1];
        vh = {vh[1:0], vga_vsync};
        @(posedge clk);
        @(negedge clk);
        if (fs) begin
            if (in_burst != 0) void'(b_addr.pop_back());
            mq.delete();
            last_m = '0; und_m = 1'b0; addr_m = base_b; pushed_m = 0;
            in_burst = 0; after_end = 1'b0; low_steps = 0;
            chk("fs_req_drop", {31'd0, bus_req}, 32'd0);
            chk("fs_addr", {2'b0, bus_addr}, {2'b0, base_b});
        end else begin
            if (rd_b) begin
                if (size_pre == 0) und_m = 1'b1;
                else               last_m = mq.pop_front();
            end
            if (ack_b && req_b) begin
                chk("beat_addr", {2'b0, addr_b}, {2'b0, addr_m});
                mq.push_back(fword(addr_m));
                addr_m++;
                pushed_m++;
                burst_acks++;
            end
            if (!req_b && bus_req) begin
                chk("issue_enable", {31'd0, en_b}, 32'd1);
                chk("issue_space", {31'd0, (DEPTH - size_pre) >= BL}, 32'd1);
                chk("issue_words", {31'd0, pushed_m < FW}, 32'd1);
                if (after_end) chk("burst_gap", {31'd0, low_steps >= 2}, 32'd1);
                remain        = FW - pushed_m;
                burst_len_exp = (remain < BL) ? remain : BL;
                burst_acks    = 0;
                in_burst      = 1;
                b_addr.push_back(bus_addr);
            end
            if (req_b && !bus_req) begin
                chk("burst_len", burst_acks, burst_len_exp);
                b_len.push_back(burst_acks);
                $display("[TB] burst @%h len %0d", b_addr[$], burst_acks);
                in_burst = 0; after_end = 1'b1; low_steps = 0;
            end
            if (req_b && bus_req)
                chk("burst_open", {31'd0, burst_acks < burst_len_exp}, 32'd1);
        end
        if (!bus_req) low_steps++;
        chk("head", dut_word(), (mq.size() > 0) ? mq[0] : last_m);
        chk("underrun", {31'd0, underrun}, {31'd0, und_m});
        chk("occupancy", {31'd0, mq.size() <= DEPTH}, 32'd1);
    endtask

    task automatic frame_start(input logic [AW-1:0] base);
        base_addr = base;
        vga_vsync = 1'b0;
        repeat (3) step();
        vga_vsync = 1'b1;
    endtask

    task automatic wait_req(input string name);
        int n = 0;
        while (!bus_req && n < 10) begin
            step();
            n++;
        end
        chk(name, {31'd0, bus_req}, 32'd1);
    endtask

    typedef struct {
        logic          rd;
        logic          ack;
        logic          exp_req;
        logic [AW-1:0] exp_addr;
        logic [31:0]   exp_word;
    } vec_t;

    vec_t tbl[8];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        int vs_cnt;
        // Cycle-by-cycle view of the first burst after a frame start at 0x100,
        // with a pop landing together with the third beat.
        tbl[0] = '{1'b0, 1'b1, 1'b0, 30'h100, 32'h0};
        tbl[1] = '{1'b0, 1'b1, 1'b1, 30'h100, 32'h0};
        tbl[2] = '{1'b0, 1'b1, 1'b1, 30'h101, fword(30'h100)};
        tbl[3] = '{1'b1, 1'b1, 1'b1, 30'h102, fword(30'h100)};
        tbl[4] = '{1'b0, 1'b1, 1'b1, 30'h103, fword(30'h101)};
        tbl[5] = '{1'b0, 1'b1, 1'b0, 30'h104, fword(30'h101)};
        tbl[6] = '{1'b0, 1'b1, 1'b0, 30'h104, fword(30'h101)};
        tbl[7] = '{1'b0, 1'b1, 1'b1, 30'h104, fword(30'h101)};

        reset_n = 1'b0; enable = 1'b1; base_addr = '0; vga_vsync = 1'b1;
        rd = 1'b0; bus_ack = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req", {31'd0, bus_req}, 32'd0);
        chk("rst_addr", {2'b0, bus_addr}, 32'd0);
        chk("rst_word", dut_word(), 32'd0);
        chk("rst_underrun", {31'd0, underrun}, 32'd0);
        reset_n = 1'b1;

        // Idle after reset: no request even with acks floating around.
        bus_ack = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("idle_req", {31'd0, bus_req}, 32'd0);
        end
        bus_ack = 1'b0;

        // Table: first burst of a frame.
        frame_start(30'h100);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("tbl%0d_req", i), {31'd0, bus_req}, {31'd0, tbl[i].exp_req});
            chk($sformatf("tbl%0d_addr", i), {2'b0, bus_addr}, {2'b0, tbl[i].exp_addr});
            chk($sformatf("tbl%0d_word", i), dut_word(), tbl[i].exp_word);
            rd = tbl[i].rd; bus_ack = tbl[i].ack;
            step();
        end
        rd = 1'b0; bus_ack = 1'b1;

        // Backpressure: FIFO fills up and fetching stalls.
        repeat (40) step();
        chk("bp_nbursts", b_len.size(), 4);
        for (int k = 0; k < 4 && k < b_len.size(); k++) begin
            chk($sformatf("bp_addr%0d", k), {2'b0, b_addr[k]}, 32'h100 + 32'(4 * k));
            chk($sformatf("bp_len%0d", k), b_len[k], BL);
        end
        chk("bp_req", {31'd0, bus_req}, 32'd0);
        chk("bp_next_addr", {2'b0, bus_addr}, 32'h110);

        for (int k = 0; k < 2; k++) begin
            rd = 1'b1; step();
            rd = 1'b0; step();
        end
        repeat (3) step();
        chk("bp_still_blocked", {31'd0, bus_req}, 32'd0);
        rd = 1'b1; step();
        rd = 1'b0;
        chk("bp_release_wait", {31'd0, bus_req}, 32'd0);
        step();
        chk("bp_release_req", {31'd0, bus_req}, 32'd1);
        chk("bp_release_addr", {2'b0, bus_addr}, 32'h110);

        // Last beat of a burst and a pop in the same clock.
        repeat (3) step();
        rd = 1'b1; step();
        rd = 1'b0;
        chk("simul_gap", {31'd0, bus_req}, 32'd0);

        // Drain to the end of the frame, then keep popping into an empty FIFO.
        rd = 1'b1;
        repeat (30) step();
        rd = 1'b0;
        chk("frame_nbursts", b_len.size(), 6);
        if (b_len.size() == 6) begin
            chk("tail_addr", {2'b0, b_addr[5]}, 32'h114);
            chk("tail_len", b_len[5], 2);
        end
        chk("underrun_set", {31'd0, underrun}, 32'd1);
        chk("hold_last", dut_word(), fword(30'h115));
        for (int i = 0; i < 5; i++) begin
            step();
            chk("done_req", {31'd0, bus_req}, 32'd0);
        end

        // New frame clears underrun and empties the FIFO.
        bus_ack = 1'b0;
        frame_start(30'h200);
        chk("fs_underrun_clr", {31'd0, underrun}, 32'd0);
        chk("fs_word_clr", dut_word(), 32'd0);

        // Vsync in the middle of a burst; the new base wraps the address space.
        wait_req("mid_req_seen");
        bus_ack = 1'b1;
        repeat (2) step();
        bus_ack = 1'b0;
        frame_start(30'h3FFFFFFE);
        chk("mid_req_drop", {31'd0, bus_req}, 32'd0);
        chk("mid_flush", dut_word(), 32'd0);
        bus_ack = 1'b1;
        step();
        chk("mid_new_req", {31'd0, bus_req}, 32'd1);
        chk("mid_new_addr", {2'b0, bus_addr}, 32'h3FFFFFFE);
        for (int i = 0; i < 30; i++) begin
            rd = ($urandom_range(0, 2) == 0);
            step();
        end

        // Random mix of enable, acks, pops and frame restarts.
        vs_cnt = 0;
        for (int i = 0; i < 1500; i++) begin
            enable  = ($urandom_range(0, 3) != 0);
            bus_ack = $urandom_range(0, 1) == 1;
            rd      = ($urandom_range(0, 9) < 3);
            if (vs_cnt > 0) begin
                vs_cnt--;
                if (vs_cnt == 0) vga_vsync = 1'b1;
            end else if ($urandom_range(0, 149) == 0) begin
                base_addr = AW'($urandom);
                vga_vsync = 1'b0;
                vs_cnt    = 3;
            end
            step();
        end
        vga_vsync = 1'b1; enable = 1'b1; rd = 1'b0; bus_ack = 1'b0;
        repeat (4) step();

        // Asynchronous reset in the middle of a burst.
        frame_start(30'h40);
        wait_req("rst_burst_seen");
        bus_ack = 1'b1;
        step();
        #2 reset_n = 1'b0;
        #1;
        chk("arst_req", {31'd0, bus_req}, 32'd0);
        chk("arst_addr", {2'b0, bus_addr}, 32'd0);
        chk("arst_word", dut_word(), 32'd0);
        chk("arst_underrun", {31'd0, underrun}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();
        for (int i = 0; i < 6; i++) begin
            step();
            chk("arst_idle_req", {31'd0, bus_req}, 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
